// File: rtl/sw_debounce_pkg.sv
// Shared constants and helpers for the slide-switch debouncer.
package sw_debounce_pkg;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
   localparam int DEFAULT_SYNC_STAGES     = 2;

   // Ceiling log2, never below 1 so a counter always has at least one bit.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return (result < 1) ? 1 : result;
   endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: multi-flop synchroniser, saturating mismatch counter, stable flop.
module sw_debounce_bit
   import sw_debounce_pkg::*;
#(
   parameter int   SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic RESET_VALUE     = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic sw_raw,
   output logic sw_stable,
   output logic sw_changed
);

   localparam int               CNT_W  = clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

   (* async_reg = "true" *) logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0] cnt;
   logic             s;

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= {SYNC_STAGES{RESET_VALUE}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw};
      end
   end

   // Any cycle of agreement discards the partial count, so only an
   // unbroken run of DEBOUNCE_CYCLES mismatches is accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt        <= '0;
         sw_stable  <= RESET_VALUE;
         sw_changed <= 1'b0;
      end else if (s == sw_stable) begin
         cnt        <= '0;
         sw_changed <= 1'b0;
      end else if (cnt == CNT_TC) begin
         cnt        <= '0;
         sw_stable  <= s;
         sw_changed <= 1'b1;
      end else begin
         cnt        <= cnt + 1'b1;
         sw_changed <= 1'b0;
      end
   end

endmodule

// File: rtl/sw_debounce.sv
// Debounces WIDTH raw slide-switch pins into a clean word plus per-bit change strobes.
module sw_debounce
   import sw_debounce_pkg::*;
#(
   parameter int               WIDTH           = 10,
   parameter int               SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int               DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_stable,
   output logic [WIDTH-1:0] sw_changed,
   output logic             sw_any_change
);

   if (WIDTH < 1) begin : g_bad_width
      $error("sw_debounce: WIDTH must be >= 1");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("sw_debounce: SYNC_STAGES must be >= 2");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
      $error("sw_debounce: DEBOUNCE_CYCLES must be >= 1");
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      sw_debounce_bit #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_VALUE     (RESET_VALUE[i])
      ) u_bit (
         .clk        (clk),
         .reset      (reset),
         .sw_raw     (sw_raw[i]),
         .sw_stable  (sw_stable[i]),
         .sw_changed (sw_changed[i])
      );
   end

   assign sw_any_change = |sw_changed;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce: one instance with 4-cycle debounce, one with 1-cycle.
module tb_sw_debounce;

   logic       clk;
   logic       reset;
   logic [9:0] sw_raw;
   logic [9:0] sw_stable;
   logic [9:0] sw_changed;
   logic       sw_any_change;

   logic       reset_f;
   logic [9:0] raw_f;
   logic [9:0] stable_f;
   logic [9:0] changed_f;
   logic       any_f;

   int total;
   int passed;
   int pulses;

   sw_debounce #(
      .WIDTH (10), .SYNC_STAGES (2), .DEBOUNCE_CYCLES (4), .RESET_VALUE (10'h000)
   ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .sw_raw        (sw_raw),
      .sw_stable     (sw_stable),
      .sw_changed    (sw_changed),
      .sw_any_change (sw_any_change)
   );

   sw_debounce #(
      .WIDTH (10), .SYNC_STAGES (2), .DEBOUNCE_CYCLES (1), .RESET_VALUE (10'h000)
   ) u_fast (
      .clk           (clk),
      .reset         (reset_f),
      .sw_raw        (raw_f),
      .sw_stable     (stable_f),
      .sw_changed    (changed_f),
      .sw_any_change (any_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      sw_raw = 10'h000;
      tick(2);
      reset = 1'b0;
      tick(2);
   endtask

   initial begin
      total   = 0;
      passed  = 0;
      reset   = 1'b1;
      sw_raw  = 10'h3FF;
      reset_f = 1'b1;
      raw_f   = 10'h000;

      // 1: reset with all switches high, then release
      tick(2);
      check("rst_stable", sw_stable, 10'h000);
      check("rst_changed", sw_changed, 10'h000);
      check("rst_any", sw_any_change, 1'b0);
      reset = 1'b0;
      tick(5);
      check("rel_edge5_stable", sw_stable, 10'h000);
      tick(1);
      check("rel_edge6_stable", sw_stable, 10'h3FF);
      check("rel_edge6_changed", sw_changed, 10'h3FF);
      check("rel_edge6_any", sw_any_change, 1'b1);
      tick(1);
      check("rel_edge7_changed", sw_changed, 10'h000);
      check("rel_edge7_any", sw_any_change, 1'b0);
      check("rel_edge7_stable", sw_stable, 10'h3FF);

      // 2: clean toggle of bit 3
      do_reset();
      sw_raw = 10'h008;
      tick(5);
      check("tog_edge5_stable", sw_stable, 10'h000);
      check("tog_edge5_changed", sw_changed, 10'h000);
      tick(1);
      check("tog_edge6_stable", sw_stable, 10'h008);
      check("tog_edge6_changed", sw_changed, 10'h008);
      check("tog_edge6_any", sw_any_change, 1'b1);
      tick(1);
      check("tog_edge7_changed", sw_changed, 10'h000);
      check("tog_edge7_stable", sw_stable, 10'h008);

      // 3: 3-cycle glitch rejected, 4-cycle pulse accepted
      do_reset();
      pulses = 0;
      sw_raw = 10'h001;
      tick(1); pulses += int'(sw_any_change);
      tick(1); pulses += int'(sw_any_change);
      tick(1); pulses += int'(sw_any_change);
      sw_raw = 10'h000;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         pulses += int'(sw_any_change);
      end
      check("glitch3_stable", sw_stable, 10'h000);
      check("glitch3_pulses", pulses, 0);
      sw_raw = 10'h001;
      tick(4);
      sw_raw = 10'h000;
      tick(1);
      check("glitch4_edge5_stable", sw_stable, 10'h000);
      tick(1);
      check("glitch4_edge6_stable", sw_stable, 10'h001);
      check("glitch4_edge6_changed", sw_changed, 10'h001);

      // 4: bit 7 bounces every 2 cycles for 20 cycles, then holds high
      do_reset();
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         sw_raw = ((i / 2) % 2 == 0) ? 10'h080 : 10'h000;
         tick(1);
         pulses += int'(sw_changed[7]);
      end
      check("bounce_stable", sw_stable, 10'h000);
      sw_raw = 10'h080;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         pulses += int'(sw_changed[7]);
      end
      check("bounce_edge5_stable", sw_stable, 10'h000);
      tick(1);
      pulses += int'(sw_changed[7]);
      check("bounce_edge6_stable", sw_stable, 10'h080);
      check("bounce_edge6_changed", sw_changed, 10'h080);
      for (int i = 0; i < 8; i++) begin
         tick(1);
         pulses += int'(sw_changed[7]);
      end
      check("bounce_pulses", pulses, 1);

      // 5: bits 1 and 9 together
      do_reset();
      sw_raw = 10'h202;
      tick(5);
      check("simul_edge5_any", sw_any_change, 1'b0);
      tick(1);
      check("simul_edge6_stable", sw_stable, 10'h202);
      check("simul_edge6_changed", sw_changed, 10'h202);
      check("simul_edge6_any", sw_any_change, 1'b1);
      tick(1);
      check("simul_edge7_any", sw_any_change, 1'b0);

      // 6: asynchronous reset in the middle of a count on bit 2
      sw_raw = 10'h206;
      tick(3);
      check("midrst_pre_stable", sw_stable, 10'h202);
      #2;
      reset = 1'b1;
      #1;
      check("midrst_async_stable", sw_stable, 10'h000);
      check("midrst_async_changed", sw_changed, 10'h000);
      sw_raw = 10'h004;
      tick(2);
      reset = 1'b0;
      tick(5);
      check("midrst_edge5_stable", sw_stable, 10'h000);
      tick(1);
      check("midrst_edge6_stable", sw_stable, 10'h004);
      check("midrst_edge6_changed", sw_changed, 10'h004);

      // 6b: same with DEBOUNCE_CYCLES = 1
      tick(1);
      reset_f = 1'b0;
      raw_f   = 10'h004;
      tick(1);
      #2;
      reset_f = 1'b1;
      #1;
      check("fast_async_stable", stable_f, 10'h000);
      tick(2);
      reset_f = 1'b0;
      tick(2);
      check("fast_edge2_stable", stable_f, 10'h000);
      tick(1);
      check("fast_edge3_stable", stable_f, 10'h004);
      check("fast_edge3_changed", changed_f, 10'h004);
      check("fast_edge3_any", any_f, 1'b1);
      tick(1);
      check("fast_edge4_changed", changed_f, 10'h000);
      raw_f = 10'h000;
      tick(3);
      check("fast_fall_stable", stable_f, 10'h000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Conditions the raw slide-switch inputs from the board pins before they reach the switch PIO's `in_port`. Each bit is synchronised into the `clk` domain and then debounced by a per-bit saturating counter. The block presents a clean, glitch-free 10-bit word plus per-bit change strobes, so software reads stable switch states and optional edge logic sees exactly one event per physical toggle.

## Interface
Parameters:
- `WIDTH`, 10, number of switch bits; must be ≥ 1.
- `SYNC_STAGES`, 2, synchroniser flop depth; must be ≥ 2.
- `DEBOUNCE_CYCLES`, 500000, consecutive mismatching cycles required to accept a new level (10 ms at 50 MHz); must be ≥ 1.
- `RESET_VALUE`, {WIDTH{1'b0}}, value loaded into the synchroniser and stable registers on reset.

Ports (one clock; reset is asynchronous and active-high):
- `clk`, input, 1, system clock; all state is on the rising edge.
- `reset`, input, 1, asynchronous active-high reset.
- `sw_raw`, input, WIDTH, asynchronous switch pins.
- `sw_stable`, output, WIDTH, debounced level; drives the PIO `in_port`.
- `sw_changed`, output, WIDTH, one-cycle pulse on each bit whose `sw_stable` just updated.
- `sw_any_change`, output, 1, OR-reduction of `sw_changed`, same cycle.

## Operation
- Per bit `i`, the chain is: synchroniser (`SYNC_STAGES` flops), giving `s[i]`; then a counter `cnt[i]` of width clog2(`DEBOUNCE_CYCLES`+1); then the register `sw_stable[i]`.
- Every cycle, for each bit:
  - If `s[i] == sw_stable[i]`: `cnt[i]` ← 0, and `sw_changed[i]` ← 0.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`: `sw_stable[i]` ← `s[i]`, `cnt[i]` ← 0, and `sw_changed[i]` ← 1.
  - Else: `cnt[i]` ← `cnt[i]`+1, and `sw_changed[i]` ← 0.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles returns `s` to equality with `sw_stable` and clears the counter. No output change occurs.
- Bits are fully independent. Simultaneous transitions on several bits each produce their own pulse, in the same cycle if their timing coincides.
- The counter can never exceed `DEBOUNCE_CYCLES-1`, so no wrap-around is possible.
- With `DEBOUNCE_CYCLES` = 1, `sw_stable` follows `s` with one cycle of delay.
- Reset values:
  - Synchroniser flops and `sw_stable` = `RESET_VALUE`.
  - `cnt` = 0.
  - `sw_changed` = 0 and `sw_any_change` = 0.
- Assertion of `reset` mid-count discards the partial count.
- After reset deasserts, a `sw_raw` that differs from `RESET_VALUE` is debounced normally and produces one `sw_changed` pulse. No pulse is produced for bits that already equal `RESET_VALUE`.

## Timing
- Latency: `sw_raw[i]` changes and is held stable before rising edge 1. Then `sw_stable[i]` and `sw_changed[i]` update at edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`.
- `sw_changed[i]` is high for exactly one cycle, the same cycle in which `sw_stable[i]` first shows the new value.
- `sw_any_change` is combinational from the registered `sw_changed`. It adds no extra latency.
- All outputs are registered except `sw_any_change`. There are no combinational paths from `sw_raw` to any output.
- `sw_raw` has no timing relation to `clk`. Only the first synchroniser flop samples it, and that flop carries the team's synchroniser attribute.

## Structure
- Sub-module `sw_debounce_bit`: one synchroniser, counter and stable flop. It is instantiated `WIDTH` times in a generate loop. The top level holds only the generate loop and the OR-reduction.
- Shared package `sw_debounce_pkg`:
  - `DEFAULT_DEBOUNCE_CYCLES` (500000) and `DEFAULT_SYNC_STAGES` (2).
  - A `clog2` function for counter sizing.
- Parameter legality checks run at elaboration: `SYNC_STAGES` ≥ 2 and `DEBOUNCE_CYCLES` ≥ 1.

## Test plan
Unless a scenario states otherwise, use `DEBOUNCE_CYCLES`=4, `SYNC_STAGES`=2, `WIDTH`=10, `RESET_VALUE`=0.

1. Reset: hold `reset` with `sw_raw`=10'h3FF → `sw_stable`=0, `sw_changed`=0. Release reset → `sw_stable`=10'h3FF at edge 6. `sw_changed`=10'h3FF for one cycle. `sw_any_change`=1 for that cycle only.
2. Clean toggle: bit 3 goes 0→1 and is held → `sw_stable[3]`=1 at edge 6, with a single `sw_changed[3]` pulse. Other bits stay unchanged with no pulses.
3. Glitch rejection: bit 0 is high for 3 cycles, then low → `sw_stable[0]` stays 0 and no pulse occurs. Repeat with high held for 4 synchronised cycles → accepted at edge 6.
4. Bounce: bit 7 alternates every 2 cycles for 20 cycles, then holds 1 → exactly one `sw_changed[7]` pulse, 6 edges after the final hold begins.
5. Simultaneous: bits 1 and 9 toggle in the same cycle → both update and both pulse in the same cycle. `sw_any_change` is high for one cycle.
6. Reset mid-count: bit 2 is mismatched for 3 cycles, then `reset` is asserted asynchronously (between edges) → `sw_stable`, `cnt` and the pulses clear immediately. After release, the full 6-edge latency applies again. Repeat with `DEBOUNCE_CYCLES`=1 → the update lands at edge 3.
